// File: rtl/arb_mux_n.sv
// N-channel registered word mux with valid/ready handshakes and a one-entry output register.
// Define ARB_MUX_RR_EN for round-robin arbitration; otherwise the lowest eligible index wins.
module arb_mux_n #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 8,
  parameter int unsigned SEL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 force_en,
  input  logic [SEL_W-1:0]     force_sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             valid_q, valid_d;
`ifdef ARB_MUX_RR_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;
`endif

  logic [N-1:0]     elig;
  logic             found;
  logic             load;
  logic             grant;
  int unsigned      gnt;
  int unsigned      fsel;
  logic [WIDTH-1:0] word;

  // Eligible set; an out-of-range forced index leaves it empty.
  always_comb begin
    elig = '0;
    fsel = 32'(force_sel);
    if (force_en) begin
      for (int unsigned k = 0; k < N; k++)
        if (k == fsel) elig[k] = in_valid[k];
    end else begin
      elig = in_valid;
    end
  end

  always_comb begin
    found = 1'b0;
    gnt   = 0;
`ifdef ARB_MUX_RR_EN
    for (int unsigned i = 0; i < N; i++) begin
      int unsigned idx;
      idx = 32'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!found && elig[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
`else
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && elig[k]) begin
        found = 1'b1;
        gnt   = k;
      end
    end
`endif
  end

  assign load  = !valid_q || out_ready;
  assign grant = load && found && !reset;

  always_comb begin
    in_ready = '0;
    word     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (k == gnt) begin
        in_ready[k] = grant;
        word        = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
`ifdef ARB_MUX_RR_EN
    ptr_d   = ptr_q;
`endif
    if (grant) begin
      data_d  = word;
      chan_d  = SEL_W'(gnt);
      valid_d = 1'b1;
`ifdef ARB_MUX_RR_EN
      ptr_d   = (gnt + 1 == N) ? '0 : SEL_W'(gnt + 1);
`endif
    end else if (load) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
`ifdef ARB_MUX_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
`ifdef ARB_MUX_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Scoreboard bench for arb_mux_n: the driver queues expected words, a monitor checks them on consumption.
module tb_arb_mux_n;

  logic          clk = 1'b0;
  logic          reset;
  logic [127:0]  in_data;
  logic [7:0]    in_valid;
  logic [7:0]    in_ready;
  logic          force_en;
  logic [2:0]    force_sel;
  logic [15:0]   out_data;
  logic [2:0]    out_chan;
  logic          out_valid;
  logic          out_ready;

  logic [5:0]    in_valid6;
  logic [5:0]    in_ready6;
  logic [15:0]   out_data6;
  logic [2:0]    out_chan6;
  logic          out_valid6;

  logic [15:0]   wdata [8];
  logic [18:0]   sbq [$];
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  always_comb
    for (int k = 0; k < 8; k++) in_data[k*16 +: 16] = wdata[k];

  arb_mux_n #(.WIDTH(16), .N(8), .SEL_W(3)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .force_en(force_en), .force_sel(force_sel), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  arb_mux_n #(.WIDTH(16), .N(6), .SEL_W(3)) dut6 (
    .clk(clk), .reset(reset), .in_data(in_data[95:0]), .in_valid(in_valid6), .in_ready(in_ready6),
    .force_en(force_en), .force_sel(force_sel), .out_data(out_data6), .out_chan(out_chan6),
    .out_valid(out_valid6), .out_ready(out_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned oh2i(input logic [7:0] v);
    for (int unsigned k = 0; k < 8; k++) if (v[k]) return k;
    return 0;
  endfunction

  // One cycle: drive, check handshake mid-cycle, queue the granted word, advance past the edge.
  task automatic cyc(input logic [7:0] v, input logic fe, input logic [2:0] fs, input logic ordy,
                     input logic [7:0] exp_rdy, input int exp_ov, input int exp_od, input string nm);
    int unsigned g;
    in_valid  = v;
    force_en  = fe;
    force_sel = fs;
    out_ready = ordy;
    @(negedge clk);
    chk({nm, "_in_ready"}, in_ready, exp_rdy);
    if (exp_ov >= 0) chk({nm, "_out_valid"}, out_valid, exp_ov);
    if (exp_od >= 0) chk({nm, "_out_data"}, out_data, exp_od);
    if (exp_rdy != 0) begin
      g = oh2i(exp_rdy);
      sbq.push_back({3'(g), wdata[g]});
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [18:0] e;
    if (!reset && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got chan %0d data %0h expected no word", out_chan, out_data);
      end else begin
        e = sbq.pop_front();
        chk("sb_out_data", out_data, e[15:0]);
        chk("sb_out_chan", out_chan, e[18:16]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 8; k++) wdata[k] = {8'(2*k), 8'(2*k+1)};
    reset = 1'b1; in_valid = 8'hFF; in_valid6 = '0;
    force_en = 1'b0; force_sel = '0; out_ready = 1'b1;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_in_ready", in_ready, 8'h00);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 16'h0);
      chk("rst_out_chan", out_chan, 3'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // All channels valid continuously.
    for (int i = 0; i < 9; i++) begin
`ifdef ARB_MUX_RR_EN
      cyc(8'hFF, 1'b0, 3'd0, 1'b1, 8'(1 << (i % 8)), (i == 0) ? 0 : 1, -1, "arb");
`else
      cyc(8'hFF, 1'b0, 3'd0, 1'b1, 8'h01, (i == 0) ? 0 : 1, -1, "arb");
`endif
    end

    for (int i = 0; i < 8; i++)
      cyc(8'hFF, 1'b1, 3'(i), 1'b1, 8'(1 << i), 1, -1, "force");

    // Forced grant of channel 2 leaves the RR pointer at 3.
    cyc(8'hFF, 1'b1, 3'd2, 1'b1, 8'h04, 1, -1, "setp");
`ifdef ARB_MUX_RR_EN
    cyc(8'h24, 1'b0, 3'd0, 1'b1, 8'h20, 1, -1, "sparse");
    cyc(8'h24, 1'b0, 3'd0, 1'b1, 8'h04, 1, -1, "sparse");
    cyc(8'h24, 1'b0, 3'd0, 1'b1, 8'h20, 1, -1, "sparse");
`else
    for (int i = 0; i < 3; i++) cyc(8'h24, 1'b0, 3'd0, 1'b1, 8'h04, 1, -1, "sparse");
`endif

    cyc(8'h00, 1'b0, 3'd0, 1'b1, 8'h00, 1, -1, "idle");
    wdata[3] = 16'h1234;
    wdata[4] = 16'h5678;
    cyc(8'h08, 1'b1, 3'd3, 1'b1, 8'h08, 0, -1, "bp_first");
    for (int i = 0; i < 3; i++)
      cyc(8'h10, 1'b1, 3'd4, 1'b0, 8'h00, 1, 16'h1234, "bp_stall");
    cyc(8'h10, 1'b1, 3'd4, 1'b1, 8'h10, 1, 16'h1234, "bp_release");
    cyc(8'h00, 1'b0, 3'd0, 1'b1, 8'h00, 1, 16'h5678, "bp_next");

    wdata[6] = 16'h00FF;
    cyc(8'h40, 1'b0, 3'd0, 1'b1, 8'h40, 0, -1, "drain_load");
    cyc(8'h00, 1'b0, 3'd0, 1'b1, 8'h00, 1, 16'h00FF, "drain_one");
    cyc(8'h00, 1'b0, 3'd0, 1'b1, 8'h00, 0, 16'h00FF, "drain_empty");
    cyc(8'h00, 1'b0, 3'd0, 1'b1, 8'h00, 0, 16'h00FF, "drain_hold");

    // Six-channel instance: forced index 6 is out of range.
    in_valid6 = 6'h3F;
    cyc(8'h00, 1'b1, 3'd6, 1'b1, 8'h00, 0, -1, "n6_oob");
    chk("n6_oob_ready", in_ready6, 6'h00);
    chk("n6_oob_valid", out_valid6, 1'b0);
    in_valid = 8'h00; force_en = 1'b1; force_sel = 3'd5;
    @(negedge clk);
    chk("n6_sel5_ready", in_ready6, 6'h20);
    @(posedge clk); #1;
    chk("n6_sel5_valid", out_valid6, 1'b1);
    chk("n6_sel5_chan", out_chan6, 3'd5);
    chk("n6_sel5_data", out_data6, wdata[5]);
    in_valid6 = '0; force_en = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
